// File: rtl/serdes_pkg.sv
// Shared constants for the serial link: bit-order selector strings and default widths.
// Both the serializer and sipo_rx import this so their bit-order choice always agrees.
package serdes_pkg;

  localparam string BIT_ORDER_MSB = "true";
  localparam string BIT_ORDER_LSB = "false";

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;

endpackage : serdes_pkg

// File: rtl/sipo_shreg.sv
// Serial-to-parallel shift register with bit counter and sync-driven realignment.
// o_word/o_done are combinational next-state views; sipo_rx registers them.
module sipo_shreg
  import serdes_pkg::*;
#(
  parameter int    DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter string DO_MSB_FIRST = BIT_ORDER_MSB
) (
  input  logic                  i_clk,
  input  logic                  i_a_rst_n,
  input  logic                  i_data_valid,
  input  logic                  i_data,
  input  logic                  i_sync,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_done
);

  localparam int                 BitCntW  = $clog2(DATA_WIDTH);
  localparam bit                 MsbFirst = (DO_MSB_FIRST == BIT_ORDER_MSB);
  localparam logic [BitCntW-1:0] LastBit  = BitCntW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] base;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    o_done    = 1'b0;
    // A sync bit throws away the partial word, so it shifts into a cleared register.
    base      = i_sync ? '0 : shreg_q;
    if (i_data_valid) begin
      if (MsbFirst) begin
        shreg_d = {base[DATA_WIDTH-2:0], i_data};
      end else begin
        shreg_d = {i_data, base[DATA_WIDTH-1:1]};
      end
      if (i_sync) begin
        bit_cnt_d = BitCntW'(1);
      end else if (bit_cnt_q == LastBit) begin
        bit_cnt_d = '0;
        o_done    = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + BitCntW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign o_word = shreg_d;

endmodule : sipo_shreg

// File: rtl/sipo_rx.sv
// Serial receiver: assembles words from a bit stream and offers them on a valid/ready port.
// Tracks dropped words with a sticky overrun flag and counts delivered words.
module sipo_rx
  import serdes_pkg::*;
#(
  parameter int    DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter string DO_MSB_FIRST = BIT_ORDER_MSB,
  parameter int    CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_a_rst_n,
  input  logic                  i_data_valid,
  input  logic                  i_data,
  input  logic                  i_sync,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic                  o_overrun,
  input  logic                  i_clr_ovr,
  output logic [CNT_WIDTH-1:0]  o_word_cnt
);

  logic                  done;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic                  xfer;

  sipo_shreg #(
    .DATA_WIDTH   (DATA_WIDTH),
    .DO_MSB_FIRST (DO_MSB_FIRST)
  ) u_shreg (
    .i_clk        (i_clk),
    .i_a_rst_n    (i_a_rst_n),
    .i_data_valid (i_data_valid),
    .i_data       (i_data),
    .i_sync       (i_sync),
    .o_word       (word),
    .o_done       (done)
  );

  // Valid/ready: a word moves on any edge where o_valid=1 and i_ready=1; while o_valid=1
  // and i_ready=0 o_data holds. The serial side never waits, so a word completing into a
  // full, unaccepted holding register is dropped and flagged as an overrun.
  assign xfer = valid_q & i_ready;

  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q & ~i_ready;
    ovr_d      = ovr_q & ~i_clr_ovr;
    word_cnt_d = word_cnt_q + CNT_WIDTH'(xfer);
    if (done) begin
      if (!valid_q || i_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        ovr_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_overrun  = ovr_q;
  assign o_word_cnt = word_cnt_q;

endmodule : sipo_rx

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: MSB-first and LSB-first instances share one stimulus stream and
// are checked each cycle against a bit-list reference model.
module tb_sipo_rx;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         dv, din, sync, ready, clr;
  logic         m_valid, m_ovr, l_valid, l_ovr;
  logic [W-1:0] m_data, l_data;
  logic [15:0]  m_cnt;
  logic [2:0]   l_cnt;

  sipo_rx #(.DATA_WIDTH(W), .DO_MSB_FIRST("true"), .CNT_WIDTH(16)) dut_msb (
    .i_clk(clk), .i_a_rst_n(rst_n), .i_data_valid(dv), .i_data(din), .i_sync(sync),
    .o_valid(m_valid), .o_data(m_data), .i_ready(ready), .o_overrun(m_ovr),
    .i_clr_ovr(clr), .o_word_cnt(m_cnt)
  );

  // Narrow counter so wrap-around is reached within the random phase.
  sipo_rx #(.DATA_WIDTH(W), .DO_MSB_FIRST("false"), .CNT_WIDTH(3)) dut_lsb (
    .i_clk(clk), .i_a_rst_n(rst_n), .i_data_valid(dv), .i_data(din), .i_sync(sync),
    .o_valid(l_valid), .o_data(l_data), .i_ready(ready), .o_overrun(l_ovr),
    .i_clr_ovr(clr), .o_word_cnt(l_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model / scoreboard ----------------
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_lsb_q[$];
  logic         bits_q[$];
  logic         ref_valid;
  logic         ref_ovr;
  logic [W-1:0] ref_msb;
  logic [W-1:0] ref_lsb;
  int unsigned  ref_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    exp_q.delete();
    exp_lsb_q.delete();
    bits_q.delete();
    ref_valid = 1'b0;
    ref_ovr   = 1'b0;
    ref_msb   = '0;
    ref_lsb   = '0;
    ref_cnt   = 0;
  endtask

  // Word-level view: collect valid bits in arrival order; W bits make one word.
  task automatic ref_edge(input logic v, input logic d, input logic s, input logic r,
                          input logic c);
    logic         hs;
    logic         nvalid;
    logic [W-1:0] wm, wl;
    hs     = ref_valid && r;
    nvalid = hs ? 1'b0 : ref_valid;
    if (hs) ref_cnt++;
    if (c) ref_ovr = 1'b0;
    if (v) begin
      if (s) bits_q.delete();
      bits_q.push_back(d);
      if (bits_q.size() == W) begin
        wm = '0;
        wl = '0;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = bits_q[i];
          wl[i]     = bits_q[i];
        end
        bits_q.delete();
        if (!ref_valid || r) begin
          ref_msb = wm;
          ref_lsb = wl;
          exp_q.push_back(wm);
          exp_lsb_q.push_back(wl);
          nvalid = 1'b1;
        end else begin
          ref_ovr = 1'b1;
        end
      end
    end
    ref_valid = nvalid;
  endtask

  task automatic compare_outputs();
    check("msb_valid", 64'(m_valid), 64'(ref_valid));
    check("msb_data",  64'(m_data),  64'(ref_msb));
    check("msb_ovr",   64'(m_ovr),   64'(ref_ovr));
    check("msb_cnt",   64'(m_cnt),   64'(16'(ref_cnt)));
    check("lsb_valid", 64'(l_valid), 64'(ref_valid));
    check("lsb_data",  64'(l_data),  64'(ref_lsb));
    check("lsb_ovr",   64'(l_ovr),   64'(ref_ovr));
    check("lsb_cnt",   64'(l_cnt),   64'(3'(ref_cnt)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(m_valid | l_valid), 64'(0));
    check({tag, "_data"},  64'(m_data | l_data),   64'(0));
    check({tag, "_ovr"},   64'(m_ovr | l_ovr),     64'(0));
    check({tag, "_cnt"},   64'(m_cnt),             64'(0));
    check({tag, "_cntl"},  64'(l_cnt),             64'(0));
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; drives one edge worth of inputs, then checks after the edge.
  task automatic step(input logic v, input logic d, input logic s, input logic r,
                      input logic c);
    dv = v; din = d; sync = s; ready = r; clr = c;
    if (ref_valid && r && exp_q.size() > 0) begin
      check("hs_msb_word", 64'(m_data), 64'(exp_q.pop_front()));
      check("hs_lsb_word", 64'(l_data), 64'(exp_lsb_q.pop_front()));
    end
    ref_edge(v, d, s, r, c);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit msb_order, input int max_gap,
                           input logic r, input bit sync_first, input logic clr_last);
    logic b;
    for (int i = 0; i < W; i++) begin
      b = msb_order ? w[W-1-i] : w[i];
      repeat ($urandom_range(max_gap, 0))
        step(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), r, 1'b0);
      step(1'b1, b, 1'(sync_first && i == 0), r, (i == W - 1) ? clr_last : 1'b0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n = 1'b0;
    dv = 1'b0; din = 1'b0; sync = 1'b0; ready = 1'b0; clr = 1'b0;
    ref_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // A5 MSB-first, consumer always ready
    send_word(8'hA5, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    check("a5_data", 64'(m_data), 64'(8'hA5));
    check("a5_valid", 64'(m_valid), 64'(1));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("a5_valid_drop", 64'(m_valid), 64'(0));
    check("a5_cnt", 64'(m_cnt), 64'(1));

    // 3C sent LSB-first
    send_word(8'h3C, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    check("3c_lsb_data", 64'(l_data), 64'(8'h3C));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // C3 with idle gaps of 0..3 cycles
    send_word(8'hC3, 1'b1, 3, 1'b1, 1'b0, 1'b0);
    check("c3_data", 64'(m_data), 64'(8'hC3));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun with consumer stalled, then clear and drain
    send_word(8'h11, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    check("ovr_hold_data", 64'(m_data), 64'(8'h11));
    check("ovr_set", 64'(m_ovr), 64'(1));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_clr", 64'(m_ovr), 64'(0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_drain_cnt", 64'(m_cnt), 64'(4));

    // Clear and new overrun on the same edge: set wins
    send_word(8'h33, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    send_word(8'h44, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    check("ovr_set_wins", 64'(m_ovr), 64'(1));
    check("ovr_set_wins_data", 64'(m_data), 64'(8'h33));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Sync realignment after a 5-bit partial word
    repeat (5) step(1'b1, 1'($urandom_range(1, 0)), 1'b0, 1'b1, 1'b0);
    send_word(8'h5A, 1'b1, 0, 1'b1, 1'b1, 1'b0);
    check("sync_data", 64'(m_data), 64'(8'h5A));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("sync_cnt", 64'(m_cnt), 64'(6));

    // Asynchronous reset mid-word
    repeat (3) step(1'b1, 1'($urandom_range(1, 0)), 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    dv = 1'b0;
    #1;
    check_all_zero("async_rst");
    ref_reset();
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_word(8'hF0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    check("post_rst_data", 64'(m_data), 64'(8'hF0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic: gaps, occasional sync/clear, random back-pressure
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)),
           1'($urandom_range(31, 0) == 0), 1'($urandom_range(2, 0) != 0),
           1'($urandom_range(15, 0) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sipo_rx

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits; legal range 2..64.
REQ-002 Parameter DO_MSB_FIRST, default "true", "true" = first received bit lands in bit DATA_WIDTH-1, "false" = first bit lands in bit 0.
REQ-003 Parameter CNT_WIDTH, default 16, width of accepted-word counter.
REQ-004 i_clk  input  1  single clock; all logic on rising edge.
REQ-005 i_a_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_data_valid  input  1  qualifies i_data on this edge.
REQ-007 i_data  input  1  serial bit.
REQ-008 i_sync  input  1  word-alignment marker; with i_data_valid, marks i_data as first bit of a new word.
REQ-009 o_valid  output  1  o_data holds an unconsumed word.
REQ-010 o_data  output  DATA_WIDTH  assembled word.
REQ-011 i_ready  input  1  consumer accepts o_data on an edge where o_valid=1.
REQ-012 o_overrun  output  1  sticky flag: a completed word was dropped.
REQ-013 i_clr_ovr  input  1  synchronous clear of o_overrun.
REQ-014 o_word_cnt  output  CNT_WIDTH  count of words delivered via handshake.

Function
REQ-015 Bits are sampled only on edges with i_data_valid=1; idle edges leave shift register and bit counter unchanged.
REQ-016 Bit counter runs 0..DATA_WIDTH-1; it increments per valid bit and wraps to 0 after the DATA_WIDTH-th bit.
REQ-017 i_sync=1 with i_data_valid=1: partial word is discarded, i_data is taken as bit 0 of the count, counter becomes 1; i_sync without i_data_valid is ignored.
REQ-018 i_sync on the edge that would be a word's last bit still restarts (partial discarded, no word emitted) unless DATA_WIDTH... no exception: restart always wins.
REQ-019 Word completes on the edge sampling its DATA_WIDTH-th valid bit; o_data/o_valid update on that same edge (o_valid high in the following cycle; latency 1 cycle from last bit presented).
REQ-020 Bit order: MSB-first shifts left inserting at bit 0; LSB-first shifts right inserting at bit DATA_WIDTH-1; the delivered word equals the word a matching-parameter serializer sent.
REQ-021 Handshake: word transfers on edge with o_valid=1 and i_ready=1; o_data stable while o_valid=1 and i_ready=0.
REQ-022 Completion with o_valid=0, or with o_valid=1 and i_ready=1 on the same edge: new word loaded, o_valid=1.
REQ-023 Completion with o_valid=1 and i_ready=0: new word dropped, o_data unchanged, o_overrun set.
REQ-024 i_clr_ovr and a new overrun on the same edge: o_overrun stays 1 (set wins).
REQ-025 o_word_cnt increments by 1 per handshake transfer, wraps from 2^CNT_WIDTH-1 to 0.
REQ-026 Serial path is never back-pressured; i_ready does not gate sampling.

Reset
REQ-027 Reset asserted: shift register, bit counter, o_data=0, o_valid=0, o_overrun=0, o_word_cnt=0, immediately without clock.
REQ-028 Reset mid-word discards the partial word; first valid bit after deassertion is bit 0 of a new word.
REQ-029 Reset deassertion is synchronised externally; block needs no internal reset synchroniser.

Structure
REQ-030 Bit-order string constants ("true"/"false" choice) and default widths reside in shared package serdes_pkg, used by both serializer and sipo_rx.
REQ-031 One sub-module sipo_shreg (shift register plus bit counter, parameterised by DATA_WIDTH/DO_MSB_FIRST, outputs word and done pulse); sipo_rx adds output register, handshake, overrun, counter.
REQ-032 No combinational path from i_data/i_data_valid/i_ready to any output.

Verification
REQ-033 MSB-first, DATA_WIDTH=8, bits 1,0,1,0,0,1,0,1 continuous valid, i_ready=1 -> o_data=8'hA5, o_valid one cycle, o_word_cnt=1.
REQ-034 LSB-first, same bit stream -> o_data=8'hA5 reversed = 8'hA5 with stream 1,0,1,0,0,1,0,1; use 8'h3C sent LSB-first -> o_data=8'h3C.
REQ-035 i_data_valid gaps of 0..3 cycles between bits of 8'hC3 -> o_data=8'hC3, completion on 8th valid bit only.
REQ-036 i_ready=0, two words 8'h11, 8'h22 -> o_data holds 8'h11, o_overrun=1; i_clr_ovr then i_ready=1 -> o_overrun=0, o_word_cnt=1.
REQ-037 i_sync after 5 bits, then 8 bits of 8'h5A -> exactly one word 8'h5A, partial discarded.
REQ-038 Reset asserted after 3 bits, released, 8 bits of 8'hF0 -> all outputs 0 during reset, then o_data=8'hF0.
